// File: rtl/cmu_pkg.sv
// Shared definitions for the control-memory (cmem) units.
// Both the chunk allocator and the chain reader/freer import this package.
package cmu_pkg;

   localparam int CMEM_ADDR_W = 10;
   localparam int CMEM_DATA_W = 16;
   localparam logic [CMEM_ADDR_W-1:0] NULL_ADDR = '0;
   localparam int ALLOC_BIT = 15;

   // One cmem word: allocation flag, reserved bits, and the link to the next chunk.
   typedef struct packed {
      logic                   alloc;
      logic [4:0]             rsvd;
      logic [CMEM_ADDR_W-1:0] next;
   } cmem_entry_t;

   typedef enum logic [2:0] {
      CR_IDLE,
      CR_RD,
      CR_WAIT,
      CR_EMIT,
      CR_FREE,
      CR_DONE,
      CR_ERR
   } cr_state_t;

endpackage

// File: rtl/cmu_chain_reader.sv
// Walks a packet's chunk chain in cmem via port b.
// Each chunk is handed to the readout path, then its entry is cleared and the address is returned to the free pool.
module cmu_chain_reader
   import cmu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 6,
   parameter int MAX_BLOCKS = 63
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] head_addr,
   output logic                  ready,
   output logic                  blk_valid,
   output logic [ADDR_WIDTH-1:0] blk_addr,
   output logic                  blk_last,
   input  logic                  blk_ready,
   output logic [ADDR_WIDTH-1:0] cm_addr,
   output logic [DATA_WIDTH-1:0] cm_wdata,
   output logic                  cm_wen,
   input  logic [DATA_WIDTH-1:0] cm_rdata,
   output logic                  free_valid,
   output logic [ADDR_WIDTH-1:0] free_addr,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  blk_count,
   output logic                  err
);

   cr_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur, nxt;
   logic [LEN_WIDTH-1:0]  count;
   cmem_entry_t           entry;
   logic [4:0]            rsvd_unused;
   logic                  link_bad;

   assign entry       = cm_rdata;
   assign rsvd_unused = entry.rsvd;

   // A fetched entry is rejected if it is free, points at itself, or would push the chain past MAX_BLOCKS.
   always_comb begin
      link_bad = !entry.alloc
              || (entry.next == cur)
              || ((count == LEN_WIDTH'(MAX_BLOCKS - 1)) && (entry.next != NULL_ADDR));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CR_IDLE: if (start) state_nxt = (head_addr == NULL_ADDR) ? CR_ERR : CR_RD;
         CR_RD:   state_nxt = CR_WAIT;
         CR_WAIT: state_nxt = link_bad ? CR_ERR : CR_EMIT;
         CR_EMIT: if (blk_ready) state_nxt = CR_FREE;
         CR_FREE: state_nxt = (nxt == NULL_ADDR) ? CR_DONE : CR_RD;
         CR_DONE: state_nxt = CR_IDLE;
         CR_ERR:  state_nxt = CR_IDLE;
         default: state_nxt = CR_IDLE;
      endcase
   end

   // Walk pointers and chunk counter; count survives DONE so blk_count stays readable until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur   <= '0;
         nxt   <= '0;
         count <= '0;
      end else begin
         case (state)
            CR_IDLE: begin
               if (start) begin
                  cur   <= head_addr;
                  nxt   <= '0;
                  count <= '0;
               end
            end
            CR_WAIT: begin
               if (!link_bad) nxt <= entry.next;
            end
            CR_FREE: begin
               count <= count + LEN_WIDTH'(1);
               if (nxt != NULL_ADDR) cur <= nxt;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ready      = (state == CR_IDLE);
      blk_valid  = 1'b0;
      blk_addr   = '0;
      blk_last   = 1'b0;
      cm_addr    = (state == CR_IDLE) ? '0 : cur;
      cm_wdata   = '0;
      cm_wen     = 1'b0;
      free_valid = 1'b0;
      free_addr  = '0;
      done       = 1'b0;
      err        = 1'b0;
      blk_count  = count;
      case (state)
         CR_EMIT: begin
            blk_valid = 1'b1;
            blk_addr  = cur;
            blk_last  = (nxt == NULL_ADDR);
         end
         CR_FREE: begin
            cm_wen     = 1'b1;
            free_valid = 1'b1;
            free_addr  = cur;
         end
         CR_DONE: done = 1'b1;
         CR_ERR:  err  = 1'b1;
         default: ;
      endcase
   end

endmodule
